conv1_ofm_writer: RTL

Writes the output of the first convolution layer to memory. The layer produces one 64-channel, 16-bit result vector per output pixel; this block captures each vector, double-buffers it, and writes it into a banked on-chip OFM memory at LANES words per cycle. The memory layout is channel-major (planes of H_OUT*W_OUT), so the next layer can read it with a plain plane/row/column address counter. The block sits between the conv1 datapath and the OFM RAM banks, and it signals when the whole 128x128x64 frame is stored.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/ofm_vec_fifo2.sv | 80 ++++++++
 rtl/conv1_ofm_writer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared constants and types for the conv1 OFM writer.
//                DSP_NO/WIDTH : channels per result vector / bits per word
//                W_OUT/H_OUT  : conv1 output frame geometry
//                LANES        : words written per cycle (= RAM banks)
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DSP_NO = 64;
  localparam int WIDTH  = 16;
  localparam int W_OUT  = 128;
  localparam int H_OUT  = 128;
  localparam int LANES  = 4;
  localparam int GROUPS = DSP_NO / LANES;
  localparam int GRP_W  = $clog2(GROUPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

  // One result vector: element c is channel c, each WIDTH bits wide.
  typedef logic [0:DSP_NO-1][WIDTH-1:0] act_vec_t;

endpackage
`default_nettype wire

// File: rtl/ofm_vec_fifo2.sv
`default_nettype none
// ============================================================================
//  Module      : ofm_vec_fifo2
//  Description : Two-entry (ping-pong) result-vector buffer.
//  Ports       : clk, rst (async, active-low)
//                clr        - empties the buffer (pointers and occupancy)
//                push       - write push_data into the tail entry
//                pop        - release the head entry
//                push_data  - vector to store
//                push_ok    - push was accepted this cycle
//                head_data  - head entry contents
//                occ        - occupancy, 0..2
//  Revision    : 1.0 - initial release
// ============================================================================
module ofm_vec_fifo2
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  act_vec_t   push_data,
  output logic       push_ok,
  output act_vec_t   head_data,
  output logic [1:0] occ
);

  act_vec_t   mem_q [0:1];
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       do_pop;
  logic       do_push;

  always_comb begin
    do_pop  = pop && (occ_q != 2'd0);
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    do_push = push && ((occ_q != 2'd2) || do_pop);
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    if (clr) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = 2'd0;
    end else begin
      if (do_pop)  head_d = ~head_q;
      if (do_push) tail_d = ~tail_q;
      case ({do_push, do_pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  // Payload storage needs no reset: it is only observed while occupied.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[tail_q] <= push_data;
  end

  assign push_ok   = do_push;
  assign head_data = mem_q[head_q];
  assign occ       = occ_q;

endmodule
`default_nettype wire

// File: rtl/conv1_ofm_writer.sv
`default_nettype none
// ============================================================================
//  Module      : conv1_ofm_writer
//  Description : Captures conv1 result vectors, double-buffers them and
//                writes them channel-major into LANES OFM RAM banks, LANES
//                words per cycle.
//  Ports       : clk, rst (async, active-low)
//                start     - arm for a new frame, clears counters/flags
//                ofm_valid - ofm_in holds a complete result vector
//                ofm_in    - one WIDTH-bit result per channel
//                wr_en     - write strobe to all banks
//                wr_addr   - shared bank address (group*plane + pixel)
//                wr_data   - lane k -> bank k, bits [k*WIDTH +: WIDTH]
//                busy      - a buffered vector is still being written
//                done      - sticky, whole frame written
//                overflow  - sticky, a vector arrived with both buffers full
//  Config      : define OFM_WRITER_RELU_EN to clamp negative words to zero
//                on capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv1_ofm_writer
  import conv_pkg::*;
#(
  parameter int FRAME_W = W_OUT,
  parameter int FRAME_H = H_OUT,
  parameter int ADDR_W  = $clog2(GROUPS * FRAME_W * FRAME_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ofm_valid,
  input  logic [WIDTH-1:0]         ofm_in [0:DSP_NO-1],
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [LANES*WIDTH-1:0]   wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int                PIXELS   = FRAME_W * FRAME_H;
  localparam int                PIX_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(PIXELS - 1);
  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(GROUPS - 1);
  localparam logic [ADDR_W-1:0] PLANE    = ADDR_W'(PIXELS);

  writer_state_t    state_q, state_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             ovf_q, ovf_d;

  logic             fifo_clr;
  logic             fifo_push;
  logic             fifo_pop;
  logic             push_ok;
  logic [1:0]       occ;
  act_vec_t         cap_vec;
  act_vec_t         head_vec;

  always_comb begin
    for (int c = 0; c < DSP_NO; c++) begin
`ifdef OFM_WRITER_RELU_EN
      cap_vec[c] = ofm_in[c][WIDTH-1] ? '0 : ofm_in[c];
`else
      cap_vec[c] = ofm_in[c];
`endif
    end
  end

  ofm_vec_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data (cap_vec),
    .push_ok   (push_ok),
    .head_data (head_vec),
    .occ       (occ)
  );

  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    pix_d     = pix_q;
    ovf_d     = ovf_q;
    fifo_clr  = 1'b0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ARMED: begin
        if (ofm_valid) begin
          fifo_push = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        fifo_push = ofm_valid;
        grp_d     = grp_q + GRP_W'(1);
        if (grp_q == LAST_GRP) begin
          fifo_pop = 1'b1;
          if (pix_q == LAST_PIX) begin
            // Frame complete: anything arriving now is surplus.
            state_d  = DONE;
            fifo_clr = 1'b1;
            pix_d    = '0;
          end else begin
            pix_d = pix_q + PIX_W'(1);
            if ((occ == 2'd1) && !ofm_valid) state_d = ARMED;
          end
        end
        // push_ok already accounts for the slot freed by this cycle's pop.
        if (ofm_valid && !push_ok) ovf_d = 1'b1;
      end
      default: ;  // IDLE and DONE ignore ofm_valid
    endcase

    // start takes priority everywhere, including aborting a drain.
    if (start) begin
      state_d   = ARMED;
      grp_d     = '0;
      pix_d     = '0;
      ovf_d     = 1'b0;
      fifo_clr  = 1'b1;
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grp_q   <= '0;
      pix_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      pix_q   <= pix_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_en    = (state_q == DRAIN);
  assign busy     = (occ != 2'd0);
  assign done     = (state_q == DONE);
  assign overflow = ovf_q;
  assign wr_addr  = wr_en ? (ADDR_W'(grp_q) * PLANE + ADDR_W'(pix_q)) : '0;

  // Group g sends channels g*LANES .. g*LANES+LANES-1, lane k to bank k.
  always_comb begin
    wr_data = '0;
    if (wr_en) begin
      for (int k = 0; k < LANES; k++) begin
        wr_data[k*WIDTH +: WIDTH] = head_vec[int'(grp_q) * LANES + k];
      end
    end
  end

endmodule
`default_nettype wire
